// File: rtl/irq_controller_if.sv
// irq_controller_if: CPU register-window bus between the address decoder and irq_controller.
interface irq_controller_if;
   logic [1:0]  wr;
   logic        cs;
   logic [4:0]  address;
   logic [15:0] din;
   logic [15:0] dout;
   modport master (output wr, cs, address, din, input dout);
   modport slave (input wr, cs, address, din, output dout);
endinterface

// File: rtl/irq_controller.sv
// irq_controller: 68000 priority interrupt controller with per-channel source routing,
// edge/level modes, auto-vector acknowledge and saturating missed-edge counters.
module irq_controller #(
   parameter int NUM_CH  = 7,
   parameter int NUM_SRC = 4,
   parameter bit SYNC_EN = 1
) (
   input  logic               clk,
   input  logic               reset,
   irq_controller_if.slave    bus,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic               iack,
   input  logic [2:0]         iack_level,
   output logic [2:0]         ipl_n
);
   logic [NUM_SRC-1:0] src_s;
   logic [6:0]         ctrl_q [NUM_CH];
   logic [6:0]         ctrl_d [NUM_CH];
   logic [7:0]         miss_q [NUM_CH];
   logic [7:0]         miss_d [NUM_CH];
   logic [NUM_CH-1:0]  pend_q, pend_d, prev_q, prev_d;
   logic [NUM_CH-1:0]  req, rise, clr;
   logic [2:0]         cur_level_q, cur_level_d, last_ack_q, last_ack_d;
   logic [15:0]        src_pad;
   logic               ack_ok;
   logic               unused_bits;

   assign unused_bits = ^{bus.wr[1], bus.din[15:7]};

   generate
      if (SYNC_EN) begin : g_sync
         logic [NUM_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
         always_comb begin
            sync1_d = src_in;
            sync2_d = sync1_q;
         end
         always_ff @(posedge clk)
            if (reset) begin
               sync1_q <= '0;
               sync2_q <= '0;
            end else begin
               sync1_q <= sync1_d;
               sync2_q <= sync2_d;
            end
         assign src_s = sync2_q;
      end else begin : g_nosync
         assign src_s = src_in;
      end
   endgenerate

   // Bit 0 is the "off" selector; selectors past NUM_SRC land on zero padding.
   assign src_pad = 16'({src_s, 1'b0});

   always_comb begin
      ack_ok      = iack && iack_level != 3'd0 && int'(iack_level) <= NUM_CH;
      last_ack_d  = ack_ok ? iack_level : last_ack_q;
      cur_level_d = 3'd0;
      for (int n = 0; n < NUM_CH; n++) begin
         req[n]    = src_pad[ctrl_q[n][3:0]] ^ ctrl_q[n][4];
         rise[n]   = req[n] & ~prev_q[n] & ctrl_q[n][6];
         clr[n]    = (bus.wr[0] && bus.address == 5'd8 && bus.din[n]) || (ack_ok && iack_level == 3'(n + 1));
         prev_d[n] = req[n];
         pend_d[n] = ctrl_q[n][5] ? req[n] & ctrl_q[n][6] : rise[n] | (pend_q[n] & ~clr[n]);
         ctrl_d[n] = (bus.wr[0] && bus.address == 5'(n)) ? bus.din[6:0] : ctrl_q[n];
         miss_d[n] = (bus.wr[0] && bus.address == 5'(16 + n)) ? 8'd0 :
                     (rise[n] && pend_q[n] && !clr[n] && !ctrl_q[n][5] && miss_q[n] != 8'hff) ? miss_q[n] + 8'd1 :
                     miss_q[n];
         if (pend_q[n] && ctrl_q[n][6]) cur_level_d = 3'(n + 1);
      end
      if (iack) cur_level_d = 3'd0;
   end

   always_ff @(posedge clk)
      if (reset) begin
         pend_q      <= '0;
         prev_q      <= '0;
         cur_level_q <= '0;
         last_ack_q  <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            ctrl_q[n] <= '0;
            miss_q[n] <= '0;
         end
      end else begin
         pend_q      <= pend_d;
         prev_q      <= prev_d;
         cur_level_q <= cur_level_d;
         last_ack_q  <= last_ack_d;
         ctrl_q      <= ctrl_d;
         miss_q      <= miss_d;
      end

   assign ipl_n = ~cur_level_q;

   always_comb begin
      bus.dout = 16'd0;
      if (bus.cs) begin
         if (bus.address == 5'd8) bus.dout = 16'(pend_q);
         if (bus.address == 5'd9) bus.dout = {5'd0, last_ack_q, 5'd0, cur_level_q};
         for (int n = 0; n < NUM_CH; n++) begin
            if (bus.address == 5'(n)) bus.dout = {9'd0, ctrl_q[n]};
            if (bus.address == 5'(16 + n)) bus.dout = {8'd0, miss_q[n]};
         end
      end
   end
endmodule
